// File: rtl/gate_test_sequencer_if.sv
// Stimulus/status bundle between the gate self-test sequencer and its controller and gate.
// The controller/bench side uses master; the sequencer uses slave.
interface gate_test_sequencer_if;
  logic       start;
  logic       hold;
  logic       c_in;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [1:0] vec_idx;

  modport master (
    output start, hold, c_in,
    input  a, b, busy, done, pass, fail_vec, vec_idx
  );

  modport slave (
    input  start, hold, c_in,
    output a, b, busy, done, pass, fail_vec, vec_idx
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Walks a two-input gate through {a,b} = 00,01,10,11, holding each vector SETTLE_CYCLES cycles
// and sampling c_in on the last cycle; done/pass/fail_vec report the run. Hold freezes the run.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  EXPECT        = 4'b1110
) (
  input logic            clk,
  input logic            rst,
  gate_test_sequencer_if.slave tst
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [1:0] k_q;
  logic [1:0] k_d;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] fail_q;
  logic [3:0] fail_d;
  logic       sample;

  // Hold beats a due sample: the vector simply stays on for another cycle.
  assign sample = (state_q == SETTLE) && !tst.hold && (cnt_q == 8'd0);
  assign k_d    = k_q + 2'd1;

  always_comb begin
    fail_d = fail_q;
    if (sample) begin
      fail_d[k_q] = tst.c_in ^ EXPECT[k_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      k_q     <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (tst.start) begin
            state_q <= SETTLE;
            cnt_q   <= RELOAD;
            k_q     <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 4'd0;
          end
        end
        SETTLE: begin
          if (!tst.hold) begin
            if (cnt_q != 8'd0) begin
              cnt_q <= cnt_q - 8'd1;
            end else begin
              fail_q <= fail_d;
              if (k_q != 2'd3) begin
                k_q   <= k_d;
                a_q   <= k_d[1];
                b_q   <= k_d[0];
                cnt_q <= RELOAD;
              end else begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= ~|fail_d;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tst.a        = a_q;
  assign tst.b        = b_q;
  assign tst.busy     = busy_q;
  assign tst.done     = done_q;
  assign tst.pass     = pass_q;
  assign tst.fail_vec = fail_q;
  assign tst.vec_idx  = k_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Self-checking bench: two sequencer builds (settle 4 and settle 1) against a progress-based model.
module tb_gate_test_sequencer;

  localparam logic [3:0] EXP   = 4'b1110;
  localparam logic [3:0] TT_OR = 4'b1110;
  localparam logic [3:0] TT_AND = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_test_sequencer_if if4();
  gate_test_sequencer_if if1();

  gate_test_sequencer #(.SETTLE_CYCLES(4), .EXPECT(EXP)) dut4 (.clk(clk), .rst(rst), .tst(if4));
  gate_test_sequencer #(.SETTLE_CYCLES(1), .EXPECT(EXP)) dut1 (.clk(clk), .rst(rst), .tst(if1));

  logic start_s [2];
  logic hold_s  [2];
  logic cin_s   [2];

  assign if4.start = start_s[0];
  assign if4.hold  = hold_s[0];
  assign if4.c_in  = cin_s[0];
  assign if1.start = start_s[1];
  assign if1.hold  = hold_s[1];
  assign if1.c_in  = cin_s[1];

  // Reference model: run progress in cycles, expected fail bits, and the gate truth table.
  bit         m_run  [2];
  bit         m_done [2];
  int         m_prog [2];
  logic [3:0] m_fail [2];
  logic [3:0] m_tt   [2];

  int nvec = 0;
  int nerr = 0;

  function automatic int settle_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d]  = 1'b0;
      m_done[d] = 1'b0;
      m_prog[d] = 0;
      m_fail[d] = 4'd0;
    end
  endtask

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check(input int d);
    int         s;
    logic [1:0] v;
    logic       oa, ob, obusy, odone, opass;
    logic [3:0] ofail;
    logic [1:0] oidx;
    s = settle_of(d);
    v = m_run[d] ? 2'(m_prog[d] / s) : (m_done[d] ? 2'd3 : 2'd0);
    if (d == 0) begin
      oa = if4.a; ob = if4.b; obusy = if4.busy; odone = if4.done;
      opass = if4.pass; ofail = if4.fail_vec; oidx = if4.vec_idx;
    end else begin
      oa = if1.a; ob = if1.b; obusy = if1.busy; odone = if1.done;
      opass = if1.pass; ofail = if1.fail_vec; oidx = if1.vec_idx;
    end
    cmp($sformatf("s%0d_a", s),        {3'b0, oa},    {3'b0, v[1]});
    cmp($sformatf("s%0d_b", s),        {3'b0, ob},    {3'b0, v[0]});
    cmp($sformatf("s%0d_vec_idx", s),  {2'b0, oidx},  {2'b0, v});
    cmp($sformatf("s%0d_busy", s),     {3'b0, obusy}, {3'b0, m_run[d]});
    cmp($sformatf("s%0d_done", s),     {3'b0, odone}, {3'b0, m_done[d]});
    cmp($sformatf("s%0d_pass", s),     {3'b0, opass}, {3'b0, (m_done[d] && m_fail[d] == 4'd0)});
    cmp($sformatf("s%0d_fail_vec", s), ofail,         m_fail[d]);
  endtask

  // Check the state left by the previous edge, then drive and model the next edge.
  task automatic step(input int d, input bit st, input bit hd);
    int   s;
    int   k;
    logic c;
    s = settle_of(d);
    @(negedge clk);
    check(d);
    if (m_run[d] && (m_prog[d] % s == s - 1)) c = m_tt[d][m_prog[d] / s];
    else c = 1'($urandom_range(1));
    start_s[d] = st;
    hold_s[d]  = hd;
    cin_s[d]   = c;
    if (!m_run[d]) begin
      if (st) begin
        m_run[d]  = 1'b1;
        m_done[d] = 1'b0;
        m_prog[d] = 0;
        m_fail[d] = 4'd0;
      end
    end else if (!hd) begin
      m_prog[d]++;
      if (m_prog[d] % s == 0) begin
        k = m_prog[d] / s - 1;
        m_fail[d][k] = c ^ EXP[k];
        if (m_prog[d] == 4 * s) begin
          m_run[d]  = 1'b0;
          m_done[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic run_test(input int d, input logic [3:0] tt, input int hold_pct,
                          input int restart_at, input int hold_from, input int hold_to);
    int n;
    m_tt[d] = tt;
    step(d, 1'b1, 1'b0);
    n = 1;
    while (!m_done[d] && n < 400) begin
      step(d, n == restart_at,
           (n >= hold_from && n <= hold_to) || ($urandom_range(99) < hold_pct));
      n++;
    end
    step(d, 1'b0, 1'b0);
    step(d, 1'b0, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      hold_s[d]  = 1'b0;
      cin_s[d]   = 1'b0;
      m_tt[d]    = TT_OR;
    end
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check(0);
    check(1);
    rst = 1'b0;

    // Directed runs on the settle-4 build.
    run_test(0, TT_OR,  0, -1, -1, -1);
    run_test(0, TT_AND, 0, -1, -1, -1);
    run_test(0, 4'b0000, 0, -1, -1, -1);
    run_test(0, TT_OR,  0,  5, -1, -1);
    run_test(0, TT_OR,  0, -1,  6,  8);
    run_test(0, TT_AND, 0, -1, -1, -1);

    // Reset in the middle of a run.
    m_tt[0] = TT_OR;
    step(0, 1'b1, 1'b0);
    repeat (5) step(0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check(0);
    check(1);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1'b0, 1'b0);
    run_test(0, TT_OR, 0, -1, -1, -1);

    // Settle-1 build.
    run_test(1, TT_OR,   0, -1, -1, -1);
    run_test(1, TT_AND,  0, -1, -1, -1);
    run_test(1, 4'b0000, 0,  2,  2,  3);

    // Randomized truth tables, hold patterns and stray starts on both builds.
    for (int i = 0; i < 24; i++) begin
      int d;
      d = int'($urandom_range(1));
      run_test(d, 4'($urandom), 25, int'($urandom_range(4 * settle_of(d))), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
